// File: rtl/mem_store_aligner.sv
`default_nettype none
// ============================================================================
// Module   : mem_store_aligner
// Purpose  : Places right-justified store data on 32-bit bus byte lanes,
//            builds byte strobes and issues one or two memory write beats.
// Revision : 1.0 - initial release
// ============================================================================
module mem_store_aligner #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_sel,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_hi_data;
  logic [3:0]  r_hi_strb;

  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [31:0] w_data_sized;
  logic        w_sel_ok;
  logic        w_misaligned;
  logic        w_illegal;
  logic [63:0] w_data64;
  logic [7:0]  w_strb8;

  // Size decode also strips the unused upper bits of the store data.
  always_comb begin
    w_mask       = 4'b0000;
    w_data_sized = 32'd0;
    w_sel_ok     = 1'b1;
    case (st_sel)
      3'b000: begin
        w_mask       = 4'b0001;
        w_data_sized = {24'd0, st_data[7:0]};
      end
      3'b001: begin
        w_mask       = 4'b0011;
        w_data_sized = {16'd0, st_data[15:0]};
      end
      3'b010: begin
        w_mask       = 4'b1111;
        w_data_sized = st_data;
      end
      default: w_sel_ok = 1'b0;
    endcase
  end

  assign w_off        = st_addr[1:0];
  assign w_data64     = {32'd0, w_data_sized} << {w_off, 3'b000};
  assign w_strb8      = {4'b0000, w_mask} << w_off;
  assign w_misaligned = ((st_sel == 3'b001) && w_off[0]) ||
                        ((st_sel == 3'b010) && (w_off != 2'b00));
  assign w_illegal    = !w_sel_ok || (!ALLOW_MISALIGNED && w_misaligned);

  assign st_ready = (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hi_data <= 32'd0;
      r_hi_strb <= 4'b0000;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'b0000;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (st_valid) begin
            if (w_illegal) begin
              r_state <= DONE;
              st_done <= 1'b1;
              st_err  <= 1'b1;
            end else begin
              r_state   <= BEAT0;
              mem_req   <= 1'b1;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= w_data64[31:0];
              mem_wstrb <= w_strb8[3:0];
              r_hi_data <= w_data64[63:32];
              r_hi_strb <= w_strb8[7:4];
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (r_hi_strb != 4'b0000) begin
              // Second beat follows immediately; address wraps at 4 GiB.
              r_state   <= BEAT1;
              mem_addr  <= mem_addr + 32'd4;
              mem_wdata <= r_hi_data;
              mem_wstrb <= r_hi_strb;
            end else begin
              r_state   <= DONE;
              mem_req   <= 1'b0;
              mem_addr  <= 32'd0;
              mem_wdata <= 32'd0;
              mem_wstrb <= 4'b0000;
              st_done   <= 1'b1;
              st_err    <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            r_state   <= DONE;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'b0000;
            st_done   <= 1'b1;
            st_err    <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          st_done <= 1'b0;
          st_err  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_store_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_store_aligner
// Purpose  : Scoreboard bench for mem_store_aligner (misaligned-split and
//            strict instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_store_aligner;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_sel = '0;
  logic        mem_ack = 1'b0;
  logic        st_ready, st_done, st_err, mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        b_valid = 1'b0;
  logic [31:0] b_addr = '0;
  logic [31:0] b_data = '0;
  logic [2:0]  b_sel = '0;
  logic        b_ack = 1'b1;
  logic        b_ready, b_done, b_err, b_req;
  logic [31:0] b_maddr, b_wdata;
  logic [3:0]  b_wstrb;

  int    errors = 0;
  int    checks = 0;
  int    ack_delay = 0;
  bit    ack_force = 1'b0;
  beat_t exp_beats[$];
  bit    exp_done[$];

  mem_store_aligner #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_sel(st_sel),
    .st_done(st_done), .st_err(st_err), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack)
  );

  mem_store_aligner #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n), .st_valid(b_valid), .st_ready(b_ready),
    .st_addr(b_addr), .st_data(b_data), .st_sel(b_sel),
    .st_done(b_done), .st_err(b_err), .mem_req(b_req),
    .mem_addr(b_maddr), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb),
    .mem_ack(b_ack)
  );

  always #5 clk = ~clk;

  // Memory responder: acks each beat after ack_delay wait cycles.
  initial begin
    int w;
    w = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        w = 0;
      end
      if (ack_force) mem_ack = 1'b1;
      else if (mem_req) begin
        if (w >= ack_delay) mem_ack = 1'b1;
        else w++;
      end
    end
  end

  // Scoreboard monitor for the main instance.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if (mem_req) begin
          if (exp_beats.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got addr=%h data=%h strb=%b, none expected",
                     mem_addr, mem_wdata, mem_wstrb);
          end else begin
            if ({mem_addr, mem_wdata, mem_wstrb} !==
                {exp_beats[0].a, exp_beats[0].d, exp_beats[0].s}) begin
              errors++;
              $display("FAIL beat: got %h/%h/%b want %h/%h/%b", mem_addr, mem_wdata,
                       mem_wstrb, exp_beats[0].a, exp_beats[0].d, exp_beats[0].s);
            end
            if (mem_ack) void'(exp_beats.pop_front());
          end
        end else if ({mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin
          errors++;
          $display("FAIL idle_bus: got %h/%h/%b want zeros", mem_addr, mem_wdata, mem_wstrb);
        end
        if (st_done) begin
          checks++;
          if (exp_done.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got st_done=1 err=%b, none expected", st_err);
          end else begin
            e = exp_done.pop_front();
            if (st_err !== e) begin
              errors++;
              $display("FAIL done_err: got %b want %b", st_err, e);
            end
          end
        end
      end
    end
  end

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    beat_t b;
    b.a = a;
    b.d = d;
    b.s = s;
    exp_beats.push_back(b);
  endtask

  // Byte-by-byte reference: each source byte i lands on lane off+i.
  task automatic push_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] sel);
    beat_t b0, b1;
    int size;
    bit hi;
    if (sel > 3'd2) begin
      exp_done.push_back(1'b1);
      return;
    end
    size = (sel == 3'd0) ? 1 : (sel == 3'd1) ? 2 : 4;
    b0.a = {addr[31:2], 2'b00};
    b1.a = b0.a + 32'd4;
    b0.d = '0; b0.s = '0; b1.d = '0; b1.s = '0;
    hi = 1'b0;
    for (int i = 0; i < size; i++) begin
      int lane;
      lane = int'(addr[1:0]) + i;
      if (lane < 4) begin
        b0.d[8*lane +: 8] = data[8*i +: 8];
        b0.s[lane] = 1'b1;
      end else begin
        b1.d[8*(lane-4) +: 8] = data[8*i +: 8];
        b1.s[lane-4] = 1'b1;
        hi = 1'b1;
      end
    end
    exp_beats.push_back(b0);
    if (hi) exp_beats.push_back(b1);
    exp_done.push_back(1'b0);
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sel);
    int n;
    n = 0;
    while (!st_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!st_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: st_ready=%b after %0d cycles, want 1", st_ready, n);
    end
    st_valid = 1'b1;
    st_addr  = addr;
    st_data  = data;
    st_sel   = sel;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    st_addr  = $urandom;
    st_data  = $urandom;
    st_sel   = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (st_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_wstrb} !==
        {1'b1, 3'b000, 68'd0}) begin
      errors++;
      $display("FAIL reset_main: got rdy=%b done=%b err=%b req=%b %h/%h/%b want 1,0,0,0,zeros",
               st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_wstrb);
    end
    checks++;
    if ({b_ready, b_done, b_err, b_req, b_maddr, b_wdata, b_wstrb} !==
        {1'b1, 3'b000, 68'd0}) begin
      errors++;
      $display("FAIL reset_strict: got rdy=%b req=%b want 1,0", b_ready, b_req);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_word;
    ack_delay = 0;
    push_beat(32'h100, 32'hDEADBEEF, 4'b1111);
    exp_done.push_back(1'b0);
    issue(32'h100, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || st_done !== 1'b0) begin
      errors++;
      $display("FAIL aligned_t1: got req=%b done=%b want req=1 done=0", mem_req, st_done);
    end
    @(negedge clk);
    checks++;
    if (st_done !== 1'b1 || st_err !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL aligned_t2: got done=%b err=%b req=%b want 1,0,0", st_done, st_err, mem_req);
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] lane_data [4];
    int lat;
    lane_data = '{32'h000000AB, 32'h0000AB00, 32'h00AB0000, 32'hAB000000};
    ack_delay = 0;
    for (int k = 0; k < 4; k++) begin
      int off;
      off = (k + 3) % 4;
      push_beat(32'h200, lane_data[off], 4'(1 << off));
      exp_done.push_back(1'b0);
      issue(32'h200 + 32'(off), 32'h123456AB, 3'b000);
      wait_done(lat);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL byte_latency off=%0d: got %0d want 2", off, lat);
      end
    end
  endtask

  task automatic test_split_word;
    int lat;
    ack_delay = 2;
    push_beat(32'h0FC, 32'hCCDD0000, 4'b1100);
    push_beat(32'h100, 32'h0000AABB, 4'b0011);
    exp_done.push_back(1'b0);
    issue(32'h0FE, 32'hAABBCCDD, 3'b010);
    wait_done(lat);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL split_word_latency: got %0d want 7", lat);
    end
    ack_delay = 0;
  endtask

  task automatic test_split_half_wrap;
    int lat;
    ack_delay = 0;
    push_beat(32'h4, 32'hEF000000, 4'b1000);
    push_beat(32'h8, 32'h000000BE, 4'b0001);
    exp_done.push_back(1'b0);
    issue(32'h7, 32'hFFFFBEEF, 3'b001);
    wait_done(lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL split_half_latency: got %0d want 3", lat);
    end
    push_beat(32'hFFFFFFFC, 32'h34000000, 4'b1000);
    push_beat(32'h00000000, 32'h00000012, 4'b0001);
    exp_done.push_back(1'b0);
    issue(32'hFFFFFFFF, 32'h00001234, 3'b001);
    wait_done(lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL wrap_latency: got %0d want 3", lat);
    end
  endtask

  task automatic test_errors;
    int lat;
    ack_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || st_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_ack_ignored: got req=%b rdy=%b want 0,1", mem_req, st_ready);
      end
    end
    ack_force = 1'b0;
    exp_done.push_back(1'b1);
    issue(32'h100, 32'h11111111, 3'b011);
    @(negedge clk);
    checks++;
    if ({st_done, st_err, mem_req, st_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL illegal_t1: got done,err,req,rdy=%b want 1100",
               {st_done, st_err, mem_req, st_ready});
    end
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1 || st_done !== 1'b0) begin
      errors++;
      $display("FAIL illegal_t2: got rdy=%b done=%b want 1,0", st_ready, st_done);
    end
    exp_done.push_back(1'b1);
    issue(32'h3, 32'h0, 3'b111);
    wait_done(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL illegal_latency: got %0d want 1", lat);
    end
  endtask

  task automatic test_strict;
    logic [31:0] t_addr [5];
    logic [31:0] t_data [5];
    logic [2:0]  t_sel  [5];
    bit          t_ok   [5];
    logic [31:0] t_wd   [5];
    logic [3:0]  t_strb [5];
    t_addr = '{32'h102, 32'h101, 32'h104, 32'h102, 32'h103};
    t_data = '{32'h11223344, 32'h5566, 32'h11223344, 32'hFFFF5566, 32'hFFFFFF77};
    t_sel  = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b000};
    t_ok   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    t_wd   = '{32'h0, 32'h0, 32'h11223344, 32'h55660000, 32'h77000000};
    t_strb = '{4'b0000, 4'b0000, 4'b1111, 4'b1100, 4'b1000};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      b_valid = 1'b1;
      b_addr  = t_addr[k];
      b_data  = t_data[k];
      b_sel   = t_sel[k];
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      b_addr  = $urandom;
      @(negedge clk);
      checks++;
      if (t_ok[k]) begin
        if ({b_req, b_done, b_maddr, b_wdata, b_wstrb} !==
            {2'b10, {t_addr[k][31:2], 2'b00}, t_wd[k], t_strb[k]}) begin
          errors++;
          $display("FAIL strict_beat %0d: got req=%b done=%b %h/%h/%b want 1,0 %h/%h/%b",
                   k, b_req, b_done, b_maddr, b_wdata, b_wstrb,
                   {t_addr[k][31:2], 2'b00}, t_wd[k], t_strb[k]);
        end
      end else if ({b_req, b_done, b_err} !== 3'b011) begin
        errors++;
        $display("FAIL strict_reject %0d: got req,done,err=%b want 011", k, {b_req, b_done, b_err});
      end
      @(negedge clk);
      checks++;
      if (t_ok[k] ? ({b_done, b_err, b_req} !== 3'b100) : (b_ready !== 1'b1)) begin
        errors++;
        $display("FAIL strict_t2 %0d: got done,err,req,rdy=%b", k, {b_done, b_err, b_req, b_ready});
      end
    end
  endtask

  task automatic test_reset_mid_store;
    int lat;
    ack_delay = 0;
    push_beat(32'h0FC, 32'hCCDD0000, 4'b1100);
    push_beat(32'h100, 32'h0000AABB, 4'b0011);
    issue(32'h0FE, 32'hAABBCCDD, 3'b010);
    @(negedge clk);
    ack_delay = 1000;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL beat1_before_reset: got req=%b addr=%h want 1,00000100", mem_req, mem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'd0 || st_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got req=%b addr=%h rdy=%b want 0,0,1", mem_req, mem_addr, st_ready);
    end
    exp_beats.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (st_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got st_done=%b want 0", st_done);
    end
    ack_delay = 0;
    push_beat(32'h300, 32'hCAFEF00D, 4'b1111);
    exp_done.push_back(1'b0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    st_valid = 1'b1;
    st_addr  = 32'h300;
    st_data  = 32'hCAFEF00D;
    st_sel   = 3'b010;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_accept: got req=%b want 1", mem_req);
    end
    wait_done(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL post_reset_done: got %0d want 1", lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] a, d;
    logic [2:0] s;
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      d = $urandom;
      s = 3'($urandom_range(0, 4));
      ack_delay = $urandom_range(0, 2);
      push_store(a, d, s);
      issue(a, d, s);
      wait_done(lat);
      checks++;
      if (lat < 0) begin
        errors++;
        $display("FAIL b2b_timeout %0d: got no st_done, want one", k);
      end
    end
  endtask

  initial begin
    #2;
    rst_n = 1'b0;
    test_reset;
    test_aligned_word;
    test_byte_lanes;
    test_split_word;
    test_split_half_wrap;
    test_errors;
    test_strict;
    test_reset_mid_store;
    test_back_to_back;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_beats.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL leftover: got beats=%0d dones=%0d pending want 0,0",
               exp_beats.size(), exp_done.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
